// File: rtl/regfile_write_arbiter.sv
// Arbitrates the single register-file write port between the writeback stage (A, priority)
// and a FIFO-buffered long-latency requester (B). Define REGARB_SCOREBOARD_EN to enable o_Hazard.
module regfile_write_arbiter #(
  parameter int DEPTH        = 4,
  parameter int STARVE_LIMIT = 8,
  parameter int ADDR_W       = 5,
  parameter int DATA_W       = 32
) (
  input  logic                       i_Clk,
  input  logic                       i_Rst,
  input  logic                       i_A_Valid,
  input  logic [ADDR_W-1:0]          i_A_Addr,
  input  logic [DATA_W-1:0]          i_A_Data,
  output logic                       o_A_Stall,
  input  logic                       i_B_Valid,
  output logic                       o_B_Ready,
  input  logic [ADDR_W-1:0]          i_B_Addr,
  input  logic [DATA_W-1:0]          i_B_Data,
  output logic                       o_RegWrite,
  output logic [ADDR_W-1:0]          o_WriteAddr,
  output logic [DATA_W-1:0]          o_WriteData,
  output logic [$clog2(DEPTH+1)-1:0] o_FifoCount,
  input  logic [ADDR_W-1:0]          i_RdAddr1,
  input  logic [ADDR_W-1:0]          i_RdAddr2,
  output logic                       o_Hazard
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int STV_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [STV_W-1:0] LIMIT_C = STV_W'(STARVE_LIMIT);
  localparam logic [ADDR_W-1:0] ADDR_ZERO = {ADDR_W{1'b0}};

  logic [ADDR_W-1:0] mem_addr_q [DEPTH];
  logic [ADDR_W-1:0] mem_addr_d [DEPTH];
  logic [DATA_W-1:0] mem_data_q [DEPTH];
  logic [DATA_W-1:0] mem_data_d [DEPTH];
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [STV_W-1:0]  starve_q, starve_d;
  logic              regwrite_q, regwrite_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;

  logic a_req, fifo_empty, force_b, push, pop, a_stall;

  // Address 0 is the hardwired zero register, so writes to it are dropped at the source.
  assign a_req      = i_A_Valid && (i_A_Addr != ADDR_ZERO);
  assign fifo_empty = (count_q == {CNT_W{1'b0}});
  assign force_b    = (starve_q == LIMIT_C) && !fifo_empty;
  assign o_B_Ready  = (count_q < DEPTH_C);
  assign push       = i_B_Valid && o_B_Ready && (i_B_Addr != ADDR_ZERO);

  always_comb begin
    pop        = 1'b0;
    a_stall    = 1'b0;
    regwrite_d = 1'b0;
    waddr_d    = waddr_q;
    wdata_d    = wdata_q;
    if (force_b) begin
      pop        = 1'b1;
      a_stall    = a_req;
      regwrite_d = 1'b1;
      waddr_d    = mem_addr_q[rd_ptr_q];
      wdata_d    = mem_data_q[rd_ptr_q];
    end else if (a_req) begin
      regwrite_d = 1'b1;
      waddr_d    = i_A_Addr;
      wdata_d    = i_A_Data;
    end else if (!fifo_empty) begin
      pop        = 1'b1;
      regwrite_d = 1'b1;
      waddr_d    = mem_addr_q[rd_ptr_q];
      wdata_d    = mem_data_q[rd_ptr_q];
    end else begin
      regwrite_d = 1'b0;
    end
  end

  always_comb begin
    mem_addr_d = mem_addr_q;
    mem_data_d = mem_data_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    if (push) begin
      mem_addr_d[wr_ptr_q] = i_B_Addr;
      mem_data_d[wr_ptr_q] = i_B_Data;
      wr_ptr_d             = wr_ptr_q + PTR_W'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Not empty and not popping means A won over a waiting B entry.
  always_comb begin
    if (pop || fifo_empty) begin
      starve_d = {STV_W{1'b0}};
    end else if (starve_q != LIMIT_C) begin
      starve_d = starve_q + STV_W'(1);
    end else begin
      starve_d = starve_q;
    end
  end

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_addr_q[i] <= {ADDR_W{1'b0}};
        mem_data_q[i] <= {DATA_W{1'b0}};
      end
      rd_ptr_q   <= {PTR_W{1'b0}};
      wr_ptr_q   <= {PTR_W{1'b0}};
      count_q    <= {CNT_W{1'b0}};
      starve_q   <= {STV_W{1'b0}};
      regwrite_q <= 1'b0;
      waddr_q    <= {ADDR_W{1'b0}};
      wdata_q    <= {DATA_W{1'b0}};
    end else begin
      mem_addr_q <= mem_addr_d;
      mem_data_q <= mem_data_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      starve_q   <= starve_d;
      regwrite_q <= regwrite_d;
      waddr_q    <= waddr_d;
      wdata_q    <= wdata_d;
    end
  end

  assign o_A_Stall   = a_stall;
  assign o_RegWrite  = regwrite_q;
  assign o_WriteAddr = waddr_q;
  assign o_WriteData = wdata_q;
  assign o_FifoCount = count_q;

`ifdef REGARB_SCOREBOARD_EN
  // Distance of a slot from the read pointer, modulo DEPTH.
  function automatic logic [PTR_W-1:0] slot_offset(input logic [PTR_W-1:0] slot,
                                                    input logic [PTR_W-1:0] head);
    return slot - head;
  endfunction

  function automatic logic addr_hit(input logic [ADDR_W-1:0] rd, input logic [ADDR_W-1:0] wr);
    return (rd != ADDR_ZERO) && (rd == wr);
  endfunction

  always_comb begin
    o_Hazard = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (CNT_W'(slot_offset(PTR_W'(i), rd_ptr_q)) < count_q) begin
        if (addr_hit(i_RdAddr1, mem_addr_q[i]) || addr_hit(i_RdAddr2, mem_addr_q[i])) begin
          o_Hazard = 1'b1;
        end else begin
          o_Hazard = o_Hazard;
        end
      end else begin
        o_Hazard = o_Hazard;
      end
    end
    if (regwrite_q && (addr_hit(i_RdAddr1, waddr_q) || addr_hit(i_RdAddr2, waddr_q))) begin
      o_Hazard = 1'b1;
    end else begin
      o_Hazard = o_Hazard;
    end
  end
`else
  logic unused_rd_addr;
  assign unused_rd_addr = ^{i_RdAddr1, i_RdAddr2};
  assign o_Hazard       = 1'b0;
`endif

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Randomized + directed bench for regfile_write_arbiter against a queue-based reference model.
module tb_regfile_write_arbiter;
  localparam int DEPTH = 4;
  localparam int LIMIT = 8;

  logic        i_Clk, i_Rst;
  logic        i_A_Valid, i_B_Valid;
  logic [4:0]  i_A_Addr, i_B_Addr, i_RdAddr1, i_RdAddr2;
  logic [31:0] i_A_Data, i_B_Data;
  logic        o_A_Stall, o_B_Ready, o_RegWrite, o_Hazard;
  logic [4:0]  o_WriteAddr;
  logic [31:0] o_WriteData;
  logic [2:0]  o_FifoCount;

  regfile_write_arbiter #(.DEPTH(DEPTH), .STARVE_LIMIT(LIMIT), .ADDR_W(5), .DATA_W(32)) dut (
    .i_Clk(i_Clk), .i_Rst(i_Rst),
    .i_A_Valid(i_A_Valid), .i_A_Addr(i_A_Addr), .i_A_Data(i_A_Data), .o_A_Stall(o_A_Stall),
    .i_B_Valid(i_B_Valid), .o_B_Ready(o_B_Ready), .i_B_Addr(i_B_Addr), .i_B_Data(i_B_Data),
    .o_RegWrite(o_RegWrite), .o_WriteAddr(o_WriteAddr), .o_WriteData(o_WriteData),
    .o_FifoCount(o_FifoCount), .i_RdAddr1(i_RdAddr1), .i_RdAddr2(i_RdAddr2), .o_Hazard(o_Hazard)
  );

  initial i_Clk = 1'b0;
  always #5 i_Clk = ~i_Clk;

  typedef struct packed { logic [4:0] addr; logic [31:0] data; } ent_t;

  // Reference model: pending B writes in arrival order, plus the expected RF port.
  ent_t        mq[$];
  int          m_starve;
  bit          m_we;
  logic [4:0]  m_addr;
  logic [31:0] m_data;

  int n_checks = 0;
  int n_errors = 0;
  bit last_stall, last_ready;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_starve = 0;
    m_we     = 1'b0;
    m_addr   = 5'd0;
    m_data   = 32'd0;
  endtask

  // One clock cycle, entered and left at a falling edge.
  task automatic step(input bit rst, input bit av, input logic [4:0] aa, input logic [31:0] ad,
                      input bit bv, input logic [4:0] ba, input logic [31:0] bd,
                      input logic [4:0] r1, input logic [4:0] r2);
    bit   areq, ready, forced, hz, was_empty, popped;
    ent_t e;
    chk("regwrite", 64'(o_RegWrite), 64'(m_we));
    chk("waddr", 64'(o_WriteAddr), 64'(m_addr));
    chk("wdata", 64'(o_WriteData), 64'(m_data));
    chk("count", 64'(o_FifoCount), 64'(mq.size()));
    i_Rst = rst; i_A_Valid = av; i_A_Addr = aa; i_A_Data = ad;
    i_B_Valid = bv; i_B_Addr = ba; i_B_Data = bd; i_RdAddr1 = r1; i_RdAddr2 = r2;
    #1;
    areq   = av && (aa != 5'd0);
    ready  = (mq.size() < DEPTH);
    forced = (m_starve == LIMIT) && (mq.size() != 0);
    hz     = 1'b0;
`ifdef REGARB_SCOREBOARD_EN
    foreach (mq[k]) begin
      if (r1 != 5'd0 && mq[k].addr == r1) hz = 1'b1;
      if (r2 != 5'd0 && mq[k].addr == r2) hz = 1'b1;
    end
    if (m_we && r1 != 5'd0 && m_addr == r1) hz = 1'b1;
    if (m_we && r2 != 5'd0 && m_addr == r2) hz = 1'b1;
`endif
    chk("a_stall", 64'(o_A_Stall), 64'(forced && areq));
    chk("b_ready", 64'(o_B_Ready), 64'(ready));
    chk("hazard", 64'(o_Hazard), 64'(hz));
    last_stall = o_A_Stall;
    last_ready = o_B_Ready;
    if (rst) begin
      model_reset();
    end else begin
      was_empty = (mq.size() == 0);
      popped    = 1'b0;
      if (forced || (!areq && !was_empty)) begin
        e = mq.pop_front();
        m_we = 1'b1; m_addr = e.addr; m_data = e.data; popped = 1'b1;
      end else if (areq) begin
        m_we = 1'b1; m_addr = aa; m_data = ad;
      end else begin
        m_we = 1'b0;
      end
      if (popped || was_empty) m_starve = 0;
      else if (m_starve < LIMIT) m_starve++;
      if (bv && ready && ba != 5'd0) begin
        e.addr = ba; e.data = bd;
        mq.push_back(e);
      end
    end
    @(negedge i_Clk);
  endtask

  task automatic do_reset();
    step(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0);
  endtask

  initial begin
    int  stall_cnt, stall_at;
    bit  seen9, any_we, any_stall;
    i_Rst = 1'b1; i_A_Valid = 1'b0; i_A_Addr = 5'd0; i_A_Data = 32'd0;
    i_B_Valid = 1'b0; i_B_Addr = 5'd0; i_B_Data = 32'd0; i_RdAddr1 = 5'd0; i_RdAddr2 = 5'd0;
    repeat (2) @(negedge i_Clk);
    model_reset();
    chk("rst_regwrite", 64'(o_RegWrite), 64'd0);
    chk("rst_count", 64'(o_FifoCount), 64'd0);
    chk("rst_ready", 64'(o_B_Ready), 64'd1);
    chk("rst_hazard", 64'(o_Hazard), 64'd0);

    // Single A write, one-cycle latency
    do_reset();
    step(1'b0, 1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0);
    chk("t1_stall", 64'(last_stall), 64'd0);
    chk("t1_we", 64'(o_RegWrite), 64'd1);
    chk("t1_addr", 64'(o_WriteAddr), 64'd5);
    chk("t1_data", 64'(o_WriteData), 64'hDEADBEEF);

    // FIFO fill under A pressure
    do_reset();
    for (int c = 0; c < 5; c++)
      step(1'b0, 1'b1, 5'd1, 32'd7, 1'b1, 5'(c + 10), 32'(c), 5'd0, 5'd0);
    chk("t2_ready5", 64'(last_ready), 64'd0);
    chk("t2_count", 64'(o_FifoCount), 64'd4);

    // Starvation forcing
    do_reset();
    step(1'b0, 1'b1, 5'd3, 32'h1, 1'b1, 5'd9, 32'h1234, 5'd0, 5'd0);
    stall_cnt = 0; stall_at = -1; seen9 = 1'b0;
    for (int c = 0; c < 12; c++) begin
      step(1'b0, 1'b1, 5'd3, 32'h1, 1'b0, 5'd0, 32'd0, 5'd9, 5'd0);
      if (last_stall) begin stall_cnt++; stall_at = c; end
      if (o_RegWrite && o_WriteAddr == 5'd9 && o_WriteData == 32'h1234) seen9 = 1'b1;
    end
    chk("t3_stall_cnt", 64'(stall_cnt), 64'd1);
    chk("t3_stall_at", 64'(stall_at), 64'd8);
    chk("t3_b_issued", 64'(seen9), 64'd1);

    // Reset drops queued entries
    do_reset();
    for (int c = 0; c < 3; c++)
      step(1'b0, 1'b1, 5'd2, 32'd2, 1'b1, 5'(c + 20), 32'(c), 5'd0, 5'd0);
    do_reset();
    chk("t4_count", 64'(o_FifoCount), 64'd0);
    chk("t4_we", 64'(o_RegWrite), 64'd0);
    chk("t4_ready", 64'(o_B_Ready), 64'd1);
    any_we = 1'b0;
    for (int c = 0; c < 6; c++) begin
      step(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0);
      any_we |= o_RegWrite;
    end
    chk("t4_no_issue", 64'(any_we), 64'd0);

    // Address 0 from both sides
    do_reset();
    any_we = 1'b0; any_stall = 1'b0;
    for (int c = 0; c < 5; c++) begin
      step(1'b0, 1'b1, 5'd0, 32'd5, 1'b1, 5'd0, 32'd6, 5'd0, 5'd0);
      any_we |= o_RegWrite; any_stall |= last_stall;
    end
    chk("t5_no_we", 64'(any_we), 64'd0);
    chk("t5_no_stall", 64'(any_stall), 64'd0);
    chk("t5_count", 64'(o_FifoCount), 64'd0);

    // Hazard tracking on a queued B write
    do_reset();
    step(1'b0, 1'b1, 5'd4, 32'd4, 1'b1, 5'd7, 32'h77, 5'd7, 5'd0);
    for (int c = 0; c < 12; c++)
      step(1'b0, 1'b1, 5'd4, 32'd4, 1'b0, 5'd0, 32'd0, 5'd7, 5'd0);

    // Random traffic with occasional resets
    do_reset();
    for (int c = 0; c < 600; c++)
      step($urandom_range(63) == 0, $urandom_range(9) < 7, 5'($urandom_range(7)), $urandom,
           $urandom_range(1) == 1, 5'($urandom_range(7)), $urandom,
           5'($urandom_range(7)), 5'($urandom_range(7)));
    step(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
